ahb_bridge_rr_sequencer: RTL and testbench

Round-robin sequencer that shares the single AHB-to-APB bridge slave port between NREQ simple requesters, such as test sequencers and register-poll engines. It accepts one-word requests and turns each into a single AHB-Lite NONSEQ transfer on the bridge. It waits out the APB access and the two-cycle error response, then returns read data and status to the winning requester. It sits directly on the bridge's AHB inputs; it is the bridge's only master.

---
 rtl/ahb_bridge_rr_sequencer_if.sv | 34 +++
 rtl/ahb_bridge_rr_sequencer.sv | 178 +++++++++++++++++
 tb/tb_ahb_bridge_rr_sequencer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_bridge_rr_sequencer_if.sv
// ahb_bridge_rr_sequencer_if
// AHB-Lite signal bundle between the round-robin sequencer (master side)
// and the AHB-to-APB bridge slave port (slave side).
// Ports (all members are 1-bit unless noted):
//   HSEL, HWRITE, HTRANS[1:0], HADDR[31:0], HWDATA[31:0], HSIZE[2:0],
//   HBURST[2:0], HPROT[3:0], HMASTLOCK, HREADYIN : master -> bridge
//   HRDATA[31:0], HREADYOUT, HRESP               : bridge -> master
interface ahb_bridge_rr_sequencer_if;
  logic        HSEL;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic        HREADYIN;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HWRITE, HTRANS, HADDR, HWDATA, HSIZE, HBURST, HPROT,
           HMASTLOCK, HREADYIN,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HWRITE, HTRANS, HADDR, HWDATA, HSIZE, HBURST, HPROT,
           HMASTLOCK, HREADYIN,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_bridge_rr_sequencer.sv
// ahb_bridge_rr_sequencer
// Shares one AHB-to-APB bridge slave port between NREQ simple requesters.
// Each granted request becomes a single NONSEQ word transfer; read data and
// error status are returned with a one-cycle DONE pulse to the winner.
// Ports:
//   HCLK, HRESET         clock and synchronous active-high reset
//   REQ[NREQ]            level requests, held until the matching DONE bit
//   REQ_ADDR/REQ_WDATA   NREQ*32 packed address / write data, REQ_WRITE[NREQ]
//   GNT[NREQ]            one-hot owner of the transfer in ADDR/DATA
//   DONE[NREQ]           one-hot completion pulse; RDATA/ERR valid with it
//   TIMEOUT              sticky watchdog flag (TO_CYCLES wait cycles)
//   ahb                  master modport towards the bridge
module ahb_bridge_rr_sequencer #(
  parameter int NREQ      = 4,
  parameter int TO_CYCLES = 256
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [NREQ-1:0]      REQ,
  input  logic [NREQ*32-1:0]   REQ_ADDR,
  input  logic [NREQ-1:0]      REQ_WRITE,
  input  logic [NREQ*32-1:0]   REQ_WDATA,
  output logic [NREQ-1:0]      GNT,
  output logic [NREQ-1:0]      DONE,
  output logic [31:0]          RDATA,
  output logic                 ERR,
  output logic                 TIMEOUT,
  ahb_bridge_rr_sequencer_if.master ahb
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TO_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t            state_q, state_d;
  logic [LW-1:0]     last_q, last_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              timeout_q, timeout_d;
  logic              hsel_q, hsel_d;
  logic [1:0]        htrans_q, htrans_d;
  logic [31:0]       haddr_q, haddr_d;
  logic [31:0]       hwdata_q, hwdata_d;
  logic              hwrite_q, hwrite_d;
  logic [CW-1:0]     wd_cnt_q, wd_cnt_d;

  logic [NREQ-1:0]   eligible;
  logic              found;
  int                win_idx;
  int                scan_idx;

  // Arbitration, transfer sequencing and watchdog. A requester whose DONE
  // is high this cycle is masked so it cannot win twice back to back.
  // The bus outputs are registered, so they are derived from the next state.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    rdata_d   = rdata_q;
    err_d     = err_q;
    timeout_d = timeout_q;
    haddr_d   = haddr_q;
    hwdata_d  = hwdata_q;
    hwrite_d  = hwrite_q;
    wd_cnt_d  = wd_cnt_q;
    found     = 1'b0;
    win_idx   = 0;
    scan_idx  = 0;
    eligible  = REQ & ~done_q;

    // Scan starting one past the last winner so every requester gets a turn.
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = (int'(last_q) + k) % NREQ;
      if (!found && eligible[scan_idx]) begin
        found   = 1'b1;
        win_idx = scan_idx;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d          = S_ADDR;
          gnt_d            = '0;
          gnt_d[win_idx]   = 1'b1;
          last_d           = LW'(win_idx);
          haddr_d          = REQ_ADDR[win_idx*32 +: 32];
          hwdata_d         = REQ_WDATA[win_idx*32 +: 32];
          hwrite_d         = REQ_WRITE[win_idx];
        end
      end
      S_ADDR: begin
        if (ahb.HREADYOUT) begin
          state_d  = S_DATA;
          wd_cnt_d = '0;
        end
      end
      S_DATA: begin
        // The first ERROR cycle has HREADYOUT low, so ERR is only ever
        // captured from the final ready cycle.
        if (ahb.HREADYOUT) begin
          state_d        = S_IDLE;
          rdata_d        = ahb.HRDATA;
          err_d          = ahb.HRESP;
          done_d[last_q] = 1'b1;
          gnt_d          = '0;
        end else begin
          if (wd_cnt_q != CW'(TO_CYCLES)) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
          end
          if (wd_cnt_q == CW'(TO_CYCLES - 1)) begin
            timeout_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    hsel_d   = (state_d == S_ADDR);
    htrans_d = hsel_d ? 2'b10 : 2'b00;
  end

  // State and output registers; LAST resets so requester 0 wins first.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= S_IDLE;
      last_q    <= LW'(NREQ - 1);
      gnt_q     <= '0;
      done_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      hsel_q    <= 1'b0;
      htrans_q  <= 2'b00;
      haddr_q   <= '0;
      hwdata_q  <= '0;
      hwrite_q  <= 1'b0;
      wd_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
      hsel_q    <= hsel_d;
      htrans_q  <= htrans_d;
      haddr_q   <= haddr_d;
      hwdata_q  <= hwdata_d;
      hwrite_q  <= hwrite_d;
      wd_cnt_q  <= wd_cnt_d;
    end
  end

  assign GNT     = gnt_q;
  assign DONE    = done_q;
  assign RDATA   = rdata_q;
  assign ERR     = err_q;
  assign TIMEOUT = timeout_q;

  assign ahb.HSEL      = hsel_q;
  assign ahb.HTRANS    = htrans_q;
  assign ahb.HADDR     = haddr_q;
  assign ahb.HWDATA    = hwdata_q;
  assign ahb.HWRITE    = hwrite_q;
  assign ahb.HSIZE     = 3'b010;
  assign ahb.HBURST    = 3'b000;
  assign ahb.HPROT     = 4'b0011;
  assign ahb.HMASTLOCK = 1'b0;
  // Sole master on the bridge, so its ready feeds straight back in.
  assign ahb.HREADYIN  = ahb.HREADYOUT;

endmodule

// File: tb/tb_ahb_bridge_rr_sequencer.sv
// tb_ahb_bridge_rr_sequencer
// Directed bench for ahb_bridge_rr_sequencer with a small behavioural
// AHB-to-APB bridge model (setup cycle, PREADY waits, two-cycle ERROR).
module tb_ahb_bridge_rr_sequencer;
  localparam int NREQ = 4;

  logic              HCLK = 1'b0;
  logic              HRESET = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*32-1:0] req_addr = '0;
  logic [NREQ-1:0]   req_write = '0;
  logic [NREQ*32-1:0] req_wdata = '0;
  logic [NREQ-1:0]   GNT, DONE;
  logic [31:0]       RDATA;
  logic              ERR, TIMEOUT;

  int check_count = 0;
  int pass_count  = 0;

  // Bridge model configuration: PREADY-low cycles, PSLVERR, PRDATA.
  int          cfg_wait  = 0;
  logic        cfg_err   = 1'b0;
  logic [31:0] cfg_rdata = '0;

  typedef enum {B_IDLE, B_SETUP, B_ACCESS, B_ERR2} bstate_t;
  bstate_t     bstate;
  int          wait_left;
  logic [31:0] lat_addr, rec_paddr, rec_pwdata;
  logic        lat_write, rec_pwrite;

  ahb_bridge_rr_sequencer_if ahb ();

  ahb_bridge_rr_sequencer #(.NREQ(NREQ), .TO_CYCLES(256)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .REQ(req), .REQ_ADDR(req_addr),
    .REQ_WRITE(req_write), .REQ_WDATA(req_wdata), .GNT(GNT), .DONE(DONE),
    .RDATA(RDATA), .ERR(ERR), .TIMEOUT(TIMEOUT), .ahb(ahb)
  );

  always #5 HCLK = ~HCLK;

  // Bridge model sequencing; rec_* hold what the APB access phase saw.
  always @(posedge HCLK) begin
    if (HRESET) begin
      bstate <= B_IDLE;
    end else begin
      case (bstate)
        B_IDLE: if (ahb.HSEL && ahb.HTRANS == 2'b10 && ahb.HREADYOUT) begin
          lat_addr  <= ahb.HADDR;
          lat_write <= ahb.HWRITE;
          bstate    <= B_SETUP;
        end
        B_SETUP: begin
          wait_left <= cfg_wait;
          bstate    <= B_ACCESS;
        end
        B_ACCESS: if (wait_left != 0) begin
          wait_left <= wait_left - 1;
        end else begin
          rec_paddr  <= lat_addr;
          rec_pwrite <= lat_write;
          rec_pwdata <= ahb.HWDATA;
          bstate     <= cfg_err ? B_ERR2 : B_IDLE;
        end
        default: bstate <= B_IDLE;
      endcase
    end
  end

  always_comb begin
    ahb.HREADYOUT = 1'b1;
    ahb.HRESP     = 1'b0;
    ahb.HRDATA    = cfg_rdata;
    case (bstate)
      B_SETUP:  ahb.HREADYOUT = 1'b0;
      B_ACCESS: begin
        if (wait_left != 0) begin
          ahb.HREADYOUT = 1'b0;
        end else begin
          ahb.HREADYOUT = !cfg_err;
          ahb.HRESP     = cfg_err;
        end
      end
      B_ERR2:   ahb.HRESP = 1'b1;
      default:  ahb.HREADYOUT = 1'b1;
    endcase
  end

  task automatic do_reset();
    @(negedge HCLK);
    HRESET = 1'b1;
    req    = '0;
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;
  endtask

  // Raises REQ[r] at a negedge (cycle 0) and waits for DONE; dcyc is -1 if
  // no DONE arrived within the bound.
  task automatic run_xfer(input int r, input logic [31:0] addr, input logic wr,
                          input logic [31:0] wd, output int dcyc,
                          output logic [NREQ-1:0] dvec, output logic [31:0] rd,
                          output logic er);
    int cyc;
    dcyc = -1; dvec = '0; rd = '0; er = 1'b0;
    @(negedge HCLK);
    req_addr[r*32 +: 32]  = addr;
    req_wdata[r*32 +: 32] = wd;
    req_write[r]          = wr;
    req[r]                = 1'b1;
    cyc = 0;
    while (cyc < 1000 && dcyc < 0) begin
      @(negedge HCLK);
      cyc++;
      if (DONE != '0) begin
        dcyc = cyc; dvec = DONE; rd = RDATA; er = ERR;
      end
    end
    req[r] = 1'b0;
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    repeat (3) @(negedge HCLK);
    check_count++; if (GNT !== 4'b0000) $display("[TB] FAIL reset_gnt got %b expected 0000", GNT); else pass_count++;
    check_count++; if (DONE !== 4'b0000) $display("[TB] FAIL reset_done got %b expected 0000", DONE); else pass_count++;
    check_count++; if ({RDATA, ERR, TIMEOUT} !== 34'd0) $display("[TB] FAIL reset_status got %h/%b/%b expected 0/0/0", RDATA, ERR, TIMEOUT); else pass_count++;
    check_count++; if ({ahb.HSEL, ahb.HTRANS, ahb.HWRITE} !== 4'b0000) $display("[TB] FAIL reset_ctrl got %b%b%b expected 0000", ahb.HSEL, ahb.HTRANS, ahb.HWRITE); else pass_count++;
    check_count++; if ({ahb.HADDR, ahb.HWDATA} !== 64'd0) $display("[TB] FAIL reset_addr_data got %h/%h expected 0/0", ahb.HADDR, ahb.HWDATA); else pass_count++;
    check_count++; if ({ahb.HSIZE, ahb.HBURST, ahb.HPROT, ahb.HMASTLOCK} !== 11'b010_000_0011_0) $display("[TB] FAIL reset_consts got %b %b %b %b expected 010 000 0011 0", ahb.HSIZE, ahb.HBURST, ahb.HPROT, ahb.HMASTLOCK); else pass_count++;
    check_count++; if (ahb.HREADYIN !== 1'b1) $display("[TB] FAIL reset_hreadyin got %b expected 1", ahb.HREADYIN); else pass_count++;
    HRESET = 1'b0;
  endtask

  task automatic test_single_read();
    cfg_wait = 0; cfg_err = 1'b0; cfg_rdata = 32'hDEAD_BEEF;
    @(negedge HCLK);
    req_addr[31:0] = 32'h0200_0010; req_write[0] = 1'b0; req[0] = 1'b1;
    @(negedge HCLK);  // cycle 1
    check_count++; if ({ahb.HSEL, ahb.HTRANS} !== 3'b110) $display("[TB] FAIL read_addr_phase got hsel=%b htrans=%b expected 1 10", ahb.HSEL, ahb.HTRANS); else pass_count++;
    check_count++; if (ahb.HADDR !== 32'h0200_0010 || ahb.HWRITE !== 1'b0) $display("[TB] FAIL read_haddr got %h/%b expected 02000010/0", ahb.HADDR, ahb.HWRITE); else pass_count++;
    check_count++; if (GNT !== 4'b0001) $display("[TB] FAIL read_gnt got %b expected 0001", GNT); else pass_count++;
    @(negedge HCLK);  // cycle 2
    check_count++; if ({ahb.HSEL, ahb.HTRANS, ahb.HREADYIN} !== 4'b0000) $display("[TB] FAIL read_data_phase got hsel=%b htrans=%b hreadyin=%b expected 0 00 0", ahb.HSEL, ahb.HTRANS, ahb.HREADYIN); else pass_count++;
    @(negedge HCLK);  // cycle 3
    check_count++; if (DONE !== 4'b0000) $display("[TB] FAIL read_early_done got %b expected 0000", DONE); else pass_count++;
    @(negedge HCLK);  // cycle 4
    check_count++; if (DONE !== 4'b0001 || RDATA !== 32'hDEAD_BEEF || ERR !== 1'b0) $display("[TB] FAIL read_done got %b/%h/%b expected 0001/deadbeef/0", DONE, RDATA, ERR); else pass_count++;
    check_count++; if (GNT !== 4'b0000) $display("[TB] FAIL read_gnt_clear got %b expected 0000", GNT); else pass_count++;
    req[0] = 1'b0;
    cfg_rdata = 32'h1111_2222;
    @(negedge HCLK);  // cycle 5
    check_count++; if (DONE !== 4'b0000 || RDATA !== 32'hDEAD_BEEF) $display("[TB] FAIL read_pulse_hold got %b/%h expected 0000/deadbeef", DONE, RDATA); else pass_count++;
  endtask

  task automatic test_write_wait();
    int dc; logic [NREQ-1:0] dv; logic [31:0] rd; logic er;
    cfg_wait = 3; cfg_err = 1'b0; cfg_rdata = 32'h0BAD_F00D;
    run_xfer(2, 32'h0200_0020, 1'b1, 32'h1234_5678, dc, dv, rd, er);
    check_count++; if (dc != 7) $display("[TB] FAIL write_latency got %0d expected 7", dc); else pass_count++;
    check_count++; if (dv !== 4'b0100 || er !== 1'b0) $display("[TB] FAIL write_done got %b/%b expected 0100/0", dv, er); else pass_count++;
    check_count++; if (rec_pwrite !== 1'b1 || rec_pwdata !== 32'h1234_5678 || rec_paddr !== 32'h0200_0020) $display("[TB] FAIL write_apb got %b/%h/%h expected 1/12345678/02000020", rec_pwrite, rec_pwdata, rec_paddr); else pass_count++;
    check_count++; if (rd !== 32'h0BAD_F00D) $display("[TB] FAIL write_rdata got %h expected 0badf00d", rd); else pass_count++;
  endtask

  task automatic test_back_to_back();
    int cyc; int d1; int d2; logic [NREQ-1:0] v1, v2;
    cfg_wait = 0; cfg_err = 1'b0;
    d1 = -1; d2 = -1; v1 = '0; v2 = '0;
    @(negedge HCLK);
    req_addr[127:96] = 32'h0200_0030; req_write[3] = 1'b0; req[3] = 1'b1;
    cyc = 0;
    while (cyc < 50 && d2 < 0) begin
      @(negedge HCLK);
      cyc++;
      if (DONE != '0) begin
        if (d1 < 0) begin d1 = cyc; v1 = DONE; end
        else begin d2 = cyc; v2 = DONE; end
      end
    end
    req[3] = 1'b0;
    check_count++; if (d1 != 4 || v1 !== 4'b1000) $display("[TB] FAIL b2b_first got cycle %0d %b expected 4 1000", d1, v1); else pass_count++;
    check_count++; if (d2 != 9 || v2 !== 4'b1000) $display("[TB] FAIL b2b_regrant got cycle %0d %b expected 9 1000", d2, v2); else pass_count++;
    repeat (2) @(negedge HCLK);
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp_done [5];
    int exp_req [5];
    int cyc; int n; int prev;
    exp_done = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_req  = '{0, 1, 2, 3, 0};
    cfg_wait = 0; cfg_err = 1'b0;
    do_reset();
    @(negedge HCLK);
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*32 +: 32] = 32'h0200_0000 + 32'(i * 256);
      req_write[i] = 1'b0;
    end
    req = 4'b1111;
    cyc = 0; n = 0; prev = 0;
    while (cyc < 100 && n < 5) begin
      @(negedge HCLK);
      cyc++;
      if (DONE != '0) begin
        check_count++; if (DONE !== exp_done[n]) $display("[TB] FAIL rr_order_%0d got %b expected %b", n, DONE, exp_done[n]); else pass_count++;
        check_count++; if (rec_paddr !== 32'h0200_0000 + 32'(exp_req[n] * 256)) $display("[TB] FAIL rr_addr_%0d got %h expected %h", n, rec_paddr, 32'h0200_0000 + 32'(exp_req[n] * 256)); else pass_count++;
        check_count++; if (cyc - prev != 4) $display("[TB] FAIL rr_gap_%0d got %0d expected 4", n, cyc - prev); else pass_count++;
        prev = cyc;
        n++;
        if (n == 5) req = '0;
      end
    end
    req = '0;
    check_count++; if (n != 5) $display("[TB] FAIL rr_count got %0d expected 5", n); else pass_count++;
    repeat (8) @(negedge HCLK);
  endtask

  task automatic test_error();
    int dc; logic [NREQ-1:0] dv; logic [31:0] rd; logic er;
    cfg_wait = 0; cfg_err = 1'b1; cfg_rdata = 32'h0;
    run_xfer(1, 32'h0200_0040, 1'b0, 32'h0, dc, dv, rd, er);
    check_count++; if (dc != 5) $display("[TB] FAIL err_latency got %0d expected 5", dc); else pass_count++;
    check_count++; if (dv !== 4'b0010 || er !== 1'b1) $display("[TB] FAIL err_done got %b/%b expected 0010/1", dv, er); else pass_count++;
    cfg_err = 1'b0; cfg_rdata = 32'hA5A5_0001;
    run_xfer(1, 32'h0200_0044, 1'b0, 32'h0, dc, dv, rd, er);
    check_count++; if (dc != 4 || dv !== 4'b0010) $display("[TB] FAIL err_recover got cycle %0d %b expected 4 0010", dc, dv); else pass_count++;
    check_count++; if (er !== 1'b0 || rd !== 32'hA5A5_0001) $display("[TB] FAIL err_recover_data got %b/%h expected 0/a5a50001", er, rd); else pass_count++;
  endtask

  task automatic test_timeout();
    int cyc; int rise; int dc;
    cfg_wait = 300; cfg_err = 1'b0; cfg_rdata = 32'h7777_0000;
    rise = -1; dc = -1;
    @(negedge HCLK);
    req_addr[31:0] = 32'h0200_0050; req_write[0] = 1'b0; req[0] = 1'b1;
    cyc = 0;
    while (cyc < 400 && dc < 0) begin
      @(negedge HCLK);
      cyc++;
      if (TIMEOUT === 1'b1 && rise < 0) rise = cyc;
      if (DONE != '0) dc = cyc;
    end
    req[0] = 1'b0;
    check_count++; if (rise != 258) $display("[TB] FAIL timeout_rise got %0d expected 258", rise); else pass_count++;
    check_count++; if (dc != 304) $display("[TB] FAIL timeout_done got %0d expected 304", dc); else pass_count++;
    repeat (5) @(negedge HCLK);
    check_count++; if (TIMEOUT !== 1'b1) $display("[TB] FAIL timeout_sticky got %b expected 1", TIMEOUT); else pass_count++;
  endtask

  task automatic test_reset_mid();
    int cyc; int dc; logic [NREQ-1:0] dv; logic seen_done;
    cfg_wait = 5; cfg_err = 1'b0;
    @(negedge HCLK);
    req_addr[95:64] = 32'h0200_0060; req_write[2] = 1'b0; req[2] = 1'b1;
    repeat (3) @(negedge HCLK);  // cycle 3, in DATA
    HRESET = 1'b1;
    @(negedge HCLK);
    check_count++; if (GNT !== 4'b0000 || ahb.HSEL !== 1'b0 || DONE !== 4'b0000) $display("[TB] FAIL midreset_state got gnt=%b hsel=%b done=%b expected 0000 0 0000", GNT, ahb.HSEL, DONE); else pass_count++;
    check_count++; if (TIMEOUT !== 1'b0) $display("[TB] FAIL midreset_timeout got %b expected 0", TIMEOUT); else pass_count++;
    req = '0;
    @(negedge HCLK);
    HRESET = 1'b0;
    seen_done = 1'b0;
    repeat (8) begin
      @(negedge HCLK);
      if (DONE != '0) seen_done = 1'b1;
    end
    check_count++; if (seen_done !== 1'b0) $display("[TB] FAIL midreset_no_done got %b expected 0", seen_done); else pass_count++;
    cfg_wait = 0;
    req_addr[31:0] = 32'h0200_0070;
    req = 4'b0101;
    cyc = 0; dc = -1; dv = '0;
    while (cyc < 50 && dc < 0) begin
      @(negedge HCLK);
      cyc++;
      if (DONE != '0) begin dc = cyc; dv = DONE; req[0] = 1'b0; end
    end
    check_count++; if (dv !== 4'b0001 || dc != 4) $display("[TB] FAIL midreset_first_winner got %b at %0d expected 0001 at 4", dv, dc); else pass_count++;
    req = '0;
    repeat (8) @(negedge HCLK);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_wait();
    test_back_to_back();
    test_round_robin();
    test_error();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
